// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC, word-addressed instruction memory with load port, IF/ID register.
// Optional performance counters are enabled with `define IF_PERF_CNT_EN.
module if_fetch_stage #(
    parameter logic [31:0] PC_RESET   = 32'h0000_0000,
    parameter int          IMEM_DEPTH = 1024,
    parameter logic [31:0] NOP_INSTN  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        imem_wr_en,
    input  logic [31:0] imem_wr_addr,
    input  logic [31:0] imem_wr_data,
    output logic [31:0] pc,
    output logic [31:0] if_id_instn,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc_plus4,
    output logic        if_id_valid,
    output logic        misalign_err,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stalled,
    output logic [31:0] perf_redirects
);

    localparam int AW = $clog2(IMEM_DEPTH);

    logic [31:0] imem [IMEM_DEPTH];

    logic [31:0] pc_q, pc_d;
    logic [31:0] instn_q, instn_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic [31:0] id_pc_plus4_q, id_pc_plus4_d;
    logic        valid_q, valid_d;
    logic        misalign_q, misalign_d;
    logic        load_valid;

    logic [31:0] pc_plus4;
    logic [31:0] fetch_instn;
    logic        unused_addr_bits;

    assign pc_plus4    = pc_q + 32'd4;
    assign fetch_instn = imem[pc_q[AW+1:2]];
    assign unused_addr_bits = ^{imem_wr_addr[31:AW+2], imem_wr_addr[1:0]};

    // Memory contents survive reset; a same-cycle fetch sees the pre-write word.
    always_ff @(posedge clk) begin
        if (imem_wr_en) begin
            imem[imem_wr_addr[AW+1:2]] <= imem_wr_data;
        end
    end

    always_comb begin
        pc_d          = pc_q;
        instn_d       = instn_q;
        id_pc_d       = id_pc_q;
        id_pc_plus4_d = id_pc_plus4_q;
        valid_d       = valid_q;
        misalign_d    = misalign_q;
        load_valid    = 1'b0;

        if (branch_taken) begin
            pc_d          = {branch_target[31:2], 2'b00};
            instn_d       = NOP_INSTN;
            id_pc_d       = 32'd0;
            id_pc_plus4_d = 32'd0;
            valid_d       = 1'b0;
            if (branch_target[1:0] != 2'b00) begin
                misalign_d = 1'b1;
            end
        end else if (stall) begin
            // A flush during stall still kills the IF/ID entry, but the PC must not advance.
            if (flush) begin
                instn_d       = NOP_INSTN;
                id_pc_d       = 32'd0;
                id_pc_plus4_d = 32'd0;
                valid_d       = 1'b0;
            end
        end else if (flush) begin
            pc_d          = pc_plus4;
            instn_d       = NOP_INSTN;
            id_pc_d       = 32'd0;
            id_pc_plus4_d = 32'd0;
            valid_d       = 1'b0;
        end else begin
            pc_d          = pc_plus4;
            instn_d       = fetch_instn;
            id_pc_d       = pc_q;
            id_pc_plus4_d = pc_plus4;
            valid_d       = 1'b1;
            load_valid    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q          <= PC_RESET;
            instn_q       <= NOP_INSTN;
            id_pc_q       <= 32'd0;
            id_pc_plus4_q <= 32'd0;
            valid_q       <= 1'b0;
            misalign_q    <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            instn_q       <= instn_d;
            id_pc_q       <= id_pc_d;
            id_pc_plus4_q <= id_pc_plus4_d;
            valid_q       <= valid_d;
            misalign_q    <= misalign_d;
        end
    end

    assign pc             = pc_q;
    assign if_id_instn    = instn_q;
    assign if_id_pc       = id_pc_q;
    assign if_id_pc_plus4 = id_pc_plus4_q;
    assign if_id_valid    = valid_q;
    assign misalign_err   = misalign_q;

`ifdef IF_PERF_CNT_EN
    logic [31:0] fetched_q, fetched_d;
    logic [31:0] stalled_q, stalled_d;
    logic [31:0] redirects_q, redirects_d;

    always_comb begin
        fetched_d   = fetched_q;
        stalled_d   = stalled_q;
        redirects_d = redirects_q;
        if (load_valid) begin
            fetched_d = fetched_q + 32'd1;
        end
        if (stall && !branch_taken) begin
            stalled_d = stalled_q + 32'd1;
        end
        if (branch_taken) begin
            redirects_d = redirects_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetched_q   <= 32'd0;
            stalled_q   <= 32'd0;
            redirects_q <= 32'd0;
        end else begin
            fetched_q   <= fetched_d;
            stalled_q   <= stalled_d;
            redirects_q <= redirects_d;
        end
    end

    assign perf_fetched   = fetched_q;
    assign perf_stalled   = stalled_q;
    assign perf_redirects = redirects_q;
`else
    logic unused_load_valid;
    assign unused_load_valid = load_valid;
    assign perf_fetched   = 32'd0;
    assign perf_stalled   = 32'd0;
    assign perf_redirects = 32'd0;
`endif

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage that feeds the decode stage of the 5-stage pipeline.
- Owns the program counter, a word-addressed instruction memory with a load port, and the IF/ID pipeline register.
- Honours stall and flush requests from hazard logic, and branch redirects resolved in EX.
- Emits a valid-tagged instruction, PC and PC+4 each cycle toward decode.

Parameters:
- PC_RESET, 32'h0000_0000, PC value loaded on reset.
- IMEM_DEPTH, 1024, instruction memory depth in 32-bit words; power of two.
- NOP_INSTN, 32'h0000_0000, instruction word inserted for a bubble.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hold PC and IF/ID contents.
- flush  in  1  replace the next IF/ID contents with a bubble.
- branch_taken  in  1  redirect fetch to branch_target.
- branch_target  in  32  redirect address from EX.
- imem_wr_en  in  1  program-load write enable.
- imem_wr_addr  in  32  byte address for the load write; bits [1:0] ignored.
- imem_wr_data  in  32  load data.
- pc  out  32  current fetch PC.
- if_id_instn  out  32  registered instruction to decode.
- if_id_pc  out  32  registered PC of if_id_instn.
- if_id_pc_plus4  out  32  registered PC+4.
- if_id_valid  out  1  1 = real instruction, 0 = bubble.
- misalign_err  out  1  sticky flag: a redirect target had nonzero bits [1:0].
- perf_fetched  out  32  count of valid instructions issued (feature-dependent).
- perf_stalled  out  32  count of stall cycles (feature-dependent).
- perf_redirects  out  32  count of taken redirects (feature-dependent).

Behaviour:
- Reset (synchronous, highest priority):
  - pc = PC_RESET; if_id_instn = NOP_INSTN; if_id_pc = 0; if_id_pc_plus4 = 0; if_id_valid = 0; misalign_err = 0; all perf counters = 0.
  - Memory contents are not cleared.
- Memory read:
  - Combinational read at word index pc[log2(IMEM_DEPTH)+1:2].
  - PCs beyond the memory size wrap modulo IMEM_DEPTH.
- Memory write:
  - Synchronous write when imem_wr_en is high, at word index imem_wr_addr[log2(IMEM_DEPTH)+1:2].
  - A write and a fetch to the same word in the same cycle: the fetch captures the old data; the new data is visible from the next cycle.
  - Writes are accepted during reset and during stall.
- Per-cycle priority when not in reset: redirect > stall > flush > normal.
  - Redirect (branch_taken = 1), regardless of stall or flush:
    - pc <= {branch_target[31:2], 2'b00}.
    - IF/ID <= bubble: instn = NOP_INSTN, valid = 0, pc fields = 0.
    - misalign_err <= 1 if branch_target[1:0] != 0.
  - Stall (stall = 1, no redirect):
    - pc and all IF/ID outputs hold their values.
    - If flush = 1 as well: IF/ID becomes a bubble and pc holds.
  - Flush only: IF/ID becomes a bubble; pc <= pc + 4.
  - Normal:
    - IF/ID <= {imem[pc], pc, pc + 4}; if_id_valid <= 1; pc <= pc + 4.
- Fetch-to-decode latency is 1 cycle: the instruction at pc appears on if_id_* after the next edge.
- Redirect penalty is 1 bubble; the target instruction is valid on the second edge after branch_taken is sampled.
- Arithmetic: pc + 4 is 32-bit modulo, so 32'hFFFF_FFFC wraps to 32'h0000_0000 with no flag.
- misalign_err is cleared only by reset.
- Leaving stall resumes from the held pc; no instruction is lost or duplicated.
- Reset asserted mid-stall or mid-redirect overrides everything on that edge.

Optional Feature:
- Macro: IF_PERF_CNT_EN.
- Defined:
  - perf_fetched increments on each edge that loads a valid instruction.
  - perf_stalled increments on each edge where stall = 1 and branch_taken = 0.
  - perf_redirects increments on each edge where branch_taken = 1.
  - All three counters wrap at 2^32 and clear on reset.
- Undefined: the three perf ports are tied to 0 and no counter registers are synthesised.

Test Plan:
- Reset then free-run:
  - Stimulus: load imem[0..3] = 0xA, 0xB, 0xC, 0xD; deassert reset.
  - Response: if_id_instn sequence 0xA, 0xB, 0xC, 0xD with if_id_pc 0, 4, 8, 12; if_id_valid = 1 from the first post-reset edge; pc = 16 after 4 edges.
- Stall hold:
  - Stimulus: assert stall for 3 cycles while pc = 8.
  - Response: pc stays 8 and if_id_instn stays 0xB; after release, 0xC then 0xD follow; perf_stalled = 3 (feature on).
- Redirect beats stall:
  - Stimulus: stall = 1, branch_taken = 1, target = 0x0000_0006.
  - Response: next edge pc = 4, if_id_valid = 0, misalign_err = 1; following edge if_id_instn = 0xB with if_id_pc = 4.
- Flush only:
  - Stimulus: flush = 1 for one cycle at pc = 0.
  - Response: if_id_valid = 0, if_id_instn = 0; pc = 4; next edge delivers 0xB.
- Write/read collision:
  - Stimulus: at pc = 0x10 with imem[4] = 0x11, write 0x22 to address 0x10 in the same cycle.
  - Response: if_id_instn = 0x11; redirect to 0x10 later fetches 0x22.
- PC wrap:
  - Stimulus: redirect to 0xFFFF_FFFC.
  - Response: IF/ID shows pc 0xFFFF_FFFC with pc_plus4 = 0; next fetch pc = 0 and reads imem[0].
